// File: rtl/thor2021_insn_queue.sv
// Thor2021 instruction queue.
// Sits between fetch and the decoder. Immediate-extension prefixes (EXI7,
// EXI23, EXI41) are absorbed into a one-deep holding register and attached
// to the next non-prefix instruction. Each attached {ir, xir, pc} triple is
// buffered in a small circular FIFO, and the head entry is offered to the
// decoder under a valid/ready handshake.
module thor2021_insn_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [47:0] NOP_IR   = 48'h0000_0000_00F1,
    parameter logic [7:0]  EXI7_OP  = 8'h50,
    parameter logic [7:0]  EXI23_OP = 8'h51,
    parameter logic [7:0]  EXI41_OP = 8'h52
) (
    input  logic                       rst_i,
    input  logic                       clk_i,
    input  logic                       flush_i,
    input  logic                       fetch_v_i,
    input  logic [47:0]                fetch_ir_i,
    input  logic [63:0]                fetch_pc_i,
    output logic                       fetch_rdy_o,
    output logic                       dec_v_o,
    output logic [47:0]                dec_ir_o,
    output logic [47:0]                dec_xir_o,
    output logic [63:0]                dec_pc_o,
    input  logic                       dec_rdy_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Pointer / occupancy / prefix-holding state
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          xpend_q, xpend_d;
    logic [47:0]   xhold_q, xhold_d;
    logic [63:0]   xpc_q, xpc_d;

    // Entry storage; contents are never reset, only the pointers are.
    logic [47:0]   ir_mem  [DEPTH];
    logic [47:0]   xir_mem [DEPTH];
    logic [63:0]   pc_mem  [DEPTH];

    // Handshake decode
    logic          accept;
    logic          is_prefix;
    logic          enq;
    logic          deq;
    logic          pfx_load;
    logic [47:0]   enq_xir;
    logic [63:0]   enq_pc;

    // Fetch ready looks only at registered occupancy, so a full queue never
    // bypasses on a same-cycle pop; the decoder side is free of fetch paths.
    assign fetch_rdy_o = (count_q < DEPTH_C);
    assign dec_v_o     = (count_q != '0);
    assign count_o     = count_q;

    // Classify the incoming word and decide this cycle's enqueue/dequeue
    always_comb begin
        accept    = fetch_v_i & fetch_rdy_o;
        is_prefix = (fetch_ir_i[7:0] == EXI7_OP)  ||
                    (fetch_ir_i[7:0] == EXI23_OP) ||
                    (fetch_ir_i[7:0] == EXI41_OP);
        // A flush discards both the offered word and the offered consume.
        enq       = accept & ~is_prefix & ~flush_i;
        pfx_load  = accept &  is_prefix & ~flush_i;
        deq       = dec_v_o & dec_rdy_i & ~flush_i;
        // An attached prefix supplies both xir and the restart address.
        enq_xir   = xpend_q ? xhold_q : NOP_IR;
        enq_pc    = xpend_q ? xpc_q   : fetch_pc_i;
    end

    // Next-state for pointers, occupancy and the held prefix
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        xpend_d = xpend_q;
        xhold_d = xhold_q;
        xpc_d   = xpc_q;

        if (flush_i) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            xpend_d = 1'b0;
        end else begin
            if (enq) begin
                wptr_d  = wptr_q + AW'(1);
                xpend_d = 1'b0;
            end
            if (deq) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // A newer prefix simply replaces an older unattached one.
            if (pfx_load) begin
                xhold_d = fetch_ir_i;
                xpc_d   = fetch_pc_i;
                xpend_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            xpend_q <= 1'b0;
            xhold_q <= '0;
            xpc_q   <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            xpend_q <= xpend_d;
            xhold_q <= xhold_d;
            xpc_q   <= xpc_d;
        end
    end

    // Entry write at the tail; no reset so the array can map to distributed RAM
    always_ff @(posedge clk_i) begin
        if (enq) begin
            ir_mem[wptr_q]  <= fetch_ir_i;
            xir_mem[wptr_q] <= enq_xir;
            pc_mem[wptr_q]  <= enq_pc;
        end
    end

    // Head presentation; idle outputs are forced to NOP / zero
    always_comb begin
        dec_ir_o  = NOP_IR;
        dec_xir_o = NOP_IR;
        dec_pc_o  = '0;
        if (dec_v_o) begin
            dec_ir_o  = ir_mem[rptr_q];
            dec_xir_o = xir_mem[rptr_q];
            dec_pc_o  = pc_mem[rptr_q];
        end
    end

endmodule

// File: tb/tb_thor2021_insn_queue.sv
// Testbench for thor2021_insn_queue: directed scenarios plus randomized
// traffic, checked by a scoreboard against a queue-level reference model.
module tb_thor2021_insn_queue;

    localparam int          DEPTH    = 4;
    localparam logic [47:0] NOP_IR   = 48'h0000_0000_00F1;
    localparam logic [7:0]  EXI7_OP  = 8'h50;
    localparam logic [7:0]  EXI23_OP = 8'h51;
    localparam logic [7:0]  EXI41_OP = 8'h52;

    logic        rst_i, clk_i, flush_i, fetch_v_i, fetch_rdy_o;
    logic [47:0] fetch_ir_i, dec_ir_o, dec_xir_o;
    logic [63:0] fetch_pc_i, dec_pc_o;
    logic        dec_v_o, dec_rdy_i;
    logic [$clog2(DEPTH):0] count_o;

    thor2021_insn_queue #(
        .DEPTH(DEPTH), .NOP_IR(NOP_IR),
        .EXI7_OP(EXI7_OP), .EXI23_OP(EXI23_OP), .EXI41_OP(EXI41_OP)
    ) dut (
        .rst_i(rst_i), .clk_i(clk_i), .flush_i(flush_i),
        .fetch_v_i(fetch_v_i), .fetch_ir_i(fetch_ir_i), .fetch_pc_i(fetch_pc_i),
        .fetch_rdy_o(fetch_rdy_o), .dec_v_o(dec_v_o), .dec_ir_o(dec_ir_o),
        .dec_xir_o(dec_xir_o), .dec_pc_o(dec_pc_o), .dec_rdy_i(dec_rdy_i),
        .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [47:0] ir;
        logic [47:0] xir;
        logic [63:0] pc;
    } ent_t;

    // Reference model: expected FIFO contents and the held prefix
    ent_t        expq[$];
    bit          m_xpend;
    logic [47:0] m_xhold;
    logic [63:0] m_xpc;

    // What was offered in the current cycle, applied after the next edge
    bit          p_acc, p_flush;
    logic [47:0] p_ir;
    logic [63:0] p_pc;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 0;
    int n_pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_pfx(input logic [47:0] w);
        return (w[7:0] == EXI7_OP) || (w[7:0] == EXI23_OP) || (w[7:0] == EXI41_OP);
    endfunction

    // Apply the previous cycle's offer to the model (the edge has occurred)
    task automatic apply_pending();
        ent_t e;
        if (p_flush) begin
            expq.delete();
            m_xpend = 0;
        end else if (p_acc) begin
            if (is_pfx(p_ir)) begin
                m_xhold = p_ir;
                m_xpc   = p_pc;
                m_xpend = 1;
            end else begin
                e.ir  = p_ir;
                e.xir = m_xpend ? m_xhold : NOP_IR;
                e.pc  = m_xpend ? m_xpc : p_pc;
                m_xpend = 0;
                expq.push_back(e);
                $display("push ir=%012h xir=%012h pc=%0h", e.ir, e.xir, e.pc);
            end
        end
        p_acc   = 0;
        p_flush = 0;
    endtask

    // One cycle of stimulus
    task automatic drive(input bit v, input logic [47:0] ir, input logic [63:0] pc,
                         input bit rdy, input bit fl);
        @(posedge clk_i);
        #1;
        apply_pending();
        fetch_v_i  = v;
        fetch_ir_i = ir;
        fetch_pc_i = pc;
        dec_rdy_i  = rdy;
        flush_i    = fl;
        p_acc   = v && (expq.size() < DEPTH);
        p_flush = fl;
        p_ir    = ir;
        p_pc    = pc;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 48'h0, 64'h0, rdy, 0);
    endtask

    // Asynchronous reset mid-cycle; the model forgets everything at once
    task automatic mid_reset();
        @(posedge clk_i);
        #1;
        apply_pending();
        fetch_v_i = 0; dec_rdy_i = 0; flush_i = 0;
        #1 rst_i = 1;
        #1;
        expq.delete();
        m_xpend = 0;
        chk("rst_dec_v", 64'(dec_v_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_rdy", 64'(fetch_rdy_o), 64'd1);
        #1 rst_i = 0;
        $display("async reset applied");
    endtask

    function automatic logic [47:0] rnd_word();
        logic [47:0] w;
        int r;
        w = {16'($urandom), $urandom};
        r = $urandom_range(0, 9);
        if (r == 0)      w[7:0] = EXI7_OP;
        else if (r == 1) w[7:0] = EXI23_OP;
        else if (r == 2) w[7:0] = EXI41_OP;
        else if (is_pfx(w)) w[7:0] = 8'h04;
        return w;
    endfunction

    // Monitor: checks stable outputs mid-cycle and pops on each handshake
    always @(negedge clk_i) begin
        ent_t e;
        if (mon_en && !rst_i) begin
            chk("count", 64'(count_o), 64'(expq.size()));
            chk("dec_v", 64'(dec_v_o), 64'(expq.size() != 0));
            chk("fetch_rdy", 64'(fetch_rdy_o), 64'(expq.size() < DEPTH));
            if (!dec_v_o) begin
                chk("idle_ir", 64'(dec_ir_o), 64'(NOP_IR));
                chk("idle_xir", 64'(dec_xir_o), 64'(NOP_IR));
                chk("idle_pc", dec_pc_o, 64'd0);
            end else if (dec_rdy_i && !flush_i) begin
                if (expq.size() == 0) begin
                    chk("pop_underflow", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    n_pops++;
                    $display("pop  ir=%012h xir=%012h pc=%0h", dec_ir_o, dec_xir_o, dec_pc_o);
                    chk("head_ir", 64'(dec_ir_o), 64'(e.ir));
                    chk("head_xir", 64'(dec_xir_o), 64'(e.xir));
                    chk("head_pc", dec_pc_o, e.pc);
                end
            end
        end
    end

    initial begin
        rst_i = 1; flush_i = 0; fetch_v_i = 0; fetch_ir_i = '0; fetch_pc_i = '0; dec_rdy_i = 0;
        p_acc = 0; p_flush = 0; m_xpend = 0; m_xhold = '0; m_xpc = '0;
        #2;
        chk("reset_rdy", 64'(fetch_rdy_o), 64'd1);
        chk("reset_dec_v", 64'(dec_v_o), 64'd0);
        chk("reset_ir", 64'(dec_ir_o), 64'(NOP_IR));
        chk("reset_xir", 64'(dec_xir_o), 64'(NOP_IR));
        chk("reset_pc", dec_pc_o, 64'd0);
        chk("reset_count", 64'(count_o), 64'd0);
        #20 rst_i = 0;
        mon_en = 1;

        // Plain instruction shows up the next cycle
        drive(1, 48'h1234_5678_9A04, 64'h100, 0, 0);
        idle(0);
        @(negedge clk_i);
        chk("first_ir", 64'(dec_ir_o), 64'h1234_5678_9A04);
        chk("first_pc", dec_pc_o, 64'h100);
        idle(1);

        // Single prefix attaches; chained prefixes keep only the last one
        drive(1, 48'hABCD_0000_0051, 64'h200, 0, 0);
        drive(1, 48'h0000_1111_2205, 64'h206, 0, 0);
        idle(1);
        drive(1, 48'h0000_0000_7750, 64'h300, 0, 0);
        drive(1, 48'h4141_4141_4152, 64'h306, 0, 0);
        drive(1, 48'h0000_3333_4406, 64'h30C, 0, 0);
        idle(0);
        @(negedge clk_i);
        chk("chain_xir", 64'(dec_xir_o), 64'h4141_4141_4152);
        chk("chain_pc", dec_pc_o, 64'h306);
        idle(1);

        // Fill to DEPTH, stall the fifth, one pop lets it in across the wrap
        for (int i = 0; i < 5; i++) drive(1, 48'h00AA_0000_0004 + 48'(i << 8), 64'h400 + 64'(i*6), 0, 0);
        drive(1, 48'h00AA_0000_0404, 64'h418, 1, 0);
        drive(1, 48'h00AA_0000_0404, 64'h418, 0, 0);
        drive(1, 48'h00AA_0000_0404, 64'h418, 0, 0);
        for (int i = 0; i < 6; i++) idle(1);

        // Full-rate streaming
        for (int i = 0; i < 20; i++) drive(1, 48'h0055_0000_0008 + 48'(i << 8), 64'h500 + 64'(i*6), 1, 0);
        idle(1); idle(1);

        // Flush with three entries and a held prefix, offered push and pop
        for (int i = 0; i < 3; i++) drive(1, 48'h0066_0000_0004 + 48'(i << 8), 64'h600 + 64'(i*6), 0, 0);
        drive(1, 48'h7777_0000_0051, 64'h612, 0, 0);
        drive(1, 48'h0066_0000_0904, 64'h618, 1, 1);
        idle(0);
        drive(1, 48'h00DD_0000_0010, 64'h700, 0, 0);
        idle(0);
        @(negedge clk_i);
        chk("post_flush_xir", 64'(dec_xir_o), 64'(NOP_IR));
        idle(1); idle(1);

        // Randomized traffic with occasional flushes and async resets
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) begin
                mid_reset();
            end else begin
                drive($urandom_range(0, 99) < 70, rnd_word(), {$urandom, $urandom},
                      $urandom_range(0, 99) < ((i / 200) % 2 ? 40 : 75),
                      $urandom_range(0, 99) < 3);
            end
        end

        for (int i = 0; i < 8; i++) idle(1);
        @(negedge clk_i);
        chk("drained", 64'(expq.size()), 64'd0);
        chk("saw_pops", 64'(n_pops > 100), 64'd1);
        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/thor2021_insn_queue.md
# thor2021_insn_queue

Instruction queue between the fetch stage and the Thor2021 decoder. It accepts one 48-bit instruction word per cycle from fetch and absorbs immediate-extension prefixes (EXI7, EXI23, EXI41), attaching each to the instruction that follows it. It buffers the resulting {ir, xir, pc} triples in a small FIFO. The head entry is presented to the decoder as its `ir`/`xir` pair under a valid/ready handshake.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, 2..16.
- `NOP_IR`, Thor2021_pkg NOP instruction word, value driven on `xir` when no prefix is attached and on idle outputs.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `clk_i`  in  1  clock; the single clock for the block.
- `flush_i`  in  1  synchronous flush (branch redirect, exception); empties the queue and drops any held prefix.
- `fetch_v_i`  in  1  fetch word valid.
- `fetch_ir_i`  in  48  fetched instruction word; opcode in [7:0].
- `fetch_pc_i`  in  64  address of `fetch_ir_i`.
- `fetch_rdy_o`  out  1  queue can accept a word this cycle.
- `dec_v_o`  out  1  head entry valid.
- `dec_ir_o`  out  48  head instruction, to decoder `ir`.
- `dec_xir_o`  out  48  attached prefix or `NOP_IR`, to decoder `xir`.
- `dec_pc_o`  out  64  restart address of head entry: the prefix address if a prefix is attached, otherwise the instruction address.
- `dec_rdy_i`  in  1  decoder consumes the head this cycle.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Accept: a word is accepted when `fetch_v_i & fetch_rdy_o`. `fetch_rdy_o = (count < DEPTH)` is combinational from registered `count` only. It does not depend on `dec_rdy_i`, so there is no full-queue bypass.
- Prefix detection: an accepted word whose opcode is EXI7, EXI23 or EXI41 is a prefix and is not enqueued.
  - It loads `xhold <= fetch_ir_i`, `xpc <= fetch_pc_i`, `xpend <= 1`.
  - A prefix arriving while `xpend` is set replaces the held one, including `xpc`. Only one prefix is ever attached.
- Enqueue: an accepted non-prefix word writes one entry at `wptr`.
  - Without a held prefix the entry is {ir=word, xir=`NOP_IR`, pc=`fetch_pc_i`}.
  - With a held prefix the entry is {ir=word, xir=`xhold`, pc=`xpc`}, and `xpend` clears in the same cycle.
  - `wptr` then increments modulo DEPTH.
- Dequeue: when `dec_v_o & dec_rdy_i`, `rptr` increments modulo DEPTH. `dec_rdy_i` is ignored while `dec_v_o`=0.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, which is legal at any occupancy below DEPTH.
- Outputs: `dec_*` are driven from the entry at `rptr`.
  - `dec_v_o = (count != 0)`.
  - While `dec_v_o`=0, `dec_ir_o`/`dec_xir_o` read `NOP_IR` and `dec_pc_o` reads 0.
- Flush: `flush_i` has priority over everything in that cycle.
  - count, `wptr`, `rptr` and `xpend` go to 0, and the word and consume offered that cycle are discarded.
  - `fetch_rdy_o` remains `count<DEPTH` that cycle; a word accepted in the flush cycle is still dropped.
- Storage entries are not reset, only pointers and flags.

## Timing
- Reset values:
  - `fetch_rdy_o`=1, `dec_v_o`=0.
  - `dec_ir_o`=`NOP_IR`, `dec_xir_o`=`NOP_IR`, `dec_pc_o`=0.
  - `count_o`=0; `xpend`, `wptr`, `rptr` = 0.
- Reset asserted mid-stream discards all entries and any held prefix immediately (asynchronous).
- Latency:
  - A non-prefix word accepted at edge n is presented on `dec_*` after edge n (usable in cycle n+1) if the queue was empty.
  - A prefix adds no entry. Its instruction appears one cycle after that instruction itself is accepted.
- Throughput: one enqueue and one dequeue per cycle sustained; full-rate streaming holds occupancy constant.
- Boundaries:
  - With count = DEPTH, `fetch_rdy_o`=0 even if `dec_rdy_i`=1, so rdy rises the cycle after the pop.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - A held prefix survives any number of idle cycles, and also survives the queue being full, until a non-prefix word, a flush or reset.

## Test plan
- Reset, DEPTH=4, push ADDI@0x100 with `dec_rdy_i`=0 → next cycle `dec_v_o`=1, `dec_ir_o`=ADDI word, `dec_xir_o`=`NOP_IR`, `dec_pc_o`=0x100, `count_o`=1.
- Push EXI23@0x200 then ADDIL@0x206 → a single entry forms, with `dec_xir_o`=EXI23 word, `dec_ir_o`=ADDIL, `dec_pc_o`=0x200; `count_o` stays 0 after the prefix alone.
- Push EXI7@0x300, EXI41@0x306, ORIL@0x30C → one entry with xir=EXI41 word and pc=0x306; the EXI7 is dropped.
- Hold `dec_rdy_i`=0 and push 5 words → `fetch_rdy_o`=0 after the 4th and the 5th stalls. Pulse `dec_rdy_i` one cycle → `fetch_rdy_o`=1 next cycle and the 5th enters; order is preserved across pointer wrap.
- Stream 20 words with `fetch_v_i`=`dec_rdy_i`=1 → one output per cycle in order and `count_o` is constant at 1.
- With 3 entries plus a held prefix, assert `flush_i` together with a push and a pop → next cycle `count_o`=0, `dec_v_o`=0. A following plain LDO gets `dec_xir_o`=`NOP_IR`, so the held prefix is confirmed discarded.
